rd_fwft_buffer: RTL and testbench
=================================

Name: rd_fwft_buffer

Overview:
- Read-side output stage of the async FIFO, clocked in the read domain.
- Consumes the read-pointer block's empty flag and the memory's combinational read data, and drives the read-increment strobe.
- Presents a first-word-fall-through valid/ready stream to the downstream consumer.
- Holds up to 2 words, so the FIFO read path stays off the consumer's ready timing and back-to-back reads run at 1 word/cycle.

Parameters:
- DATA_SIZE, 8: width of a FIFO word.

Ports:
- rclk  input  1  read-domain clock, rising edge.
- rrst_n  input  1  read-domain reset, asynchronous, active-low.
- rempty  input  1  registered empty flag from the read-pointer block.
- rdata  input  DATA_SIZE  memory read data for the current read address; combinational, valid in the same cycle.
- rinc  output  1  read increment to the read-pointer block.
- rflush  input  1  synchronous discard of buffered words.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_SIZE  head word.
- out_count  output  2  number of words held (0..2).

Behaviour:
- Storage: head register (drives out_data), skid register, 2-bit count_q. Registers only, no RAM.
- Reset (rrst_n low, asynchronous): count_q=0, head=0, skid=0. Therefore out_valid=0, out_data=0, out_count=0, rinc=0.
- rinc = ~rempty & (count_q != 2) & ~rflush. It is combinational from registered state and inputs only and never depends on out_ready.
- push = rinc. The word captured at the next rclk edge is rdata sampled in the same cycle rinc is high.
- pop = out_valid & out_ready. out_valid = (count_q != 0). out_count = count_q.
- Latency: a word visible at rdata while rempty=0 and count_q=0 appears on out_data with out_valid=1 one cycle later.
- Next-state by (count_q, push, pop):
  - 0, push: head<=rdata, count=1.
  - 1, push, no pop: skid<=rdata, count=2.
  - 1, push, pop: head<=rdata, count=1.
  - 1, pop only: count=0; head is held, not cleared.
  - 2, pop: head<=skid, count=1. Push is impossible at count 2.
  - No push, no pop: hold all state.
- Ordering is strictly FIFO. Words leave in the order rinc consumed them, with no duplication and no loss.
- out_data must remain stable while out_valid=1 and out_ready=0. count_q==2 with no pop holds both registers.
- rflush=1: count_q<=0 at the next edge and rinc is forced 0 that cycle. Buffered words are discarded. FIFO pointers are untouched, so words still in the FIFO remain. pop in the flush cycle is ignored for counting, though the consumer did see the transfer. head and skid contents are don't-care after a flush.
- rempty is never inferred. If rempty=1, no push occurs, even when count_q=0.
- Sustained throughput: with rempty=0 and out_ready=1 continuously, count_q settles at 1 and one word transfers every cycle.
- Reset asserted mid-transfer clears the buffer immediately. The first out_valid after reset release requires rempty=0 for at least one cycle.
- Assertions for the bench:
  - count_q never reaches 3.
  - rinc is never high when rempty=1.
  - rinc is never high when count_q=2.
  - out_data is unchanged while out_valid & ~out_ready.

Test Plan:
- Reset then idle: rrst_n low with rempty=0, rdata=8'hA5 -> out_valid=0, out_count=0, rinc=0. Release reset -> rinc=1, and the next edge gives out_valid=1, out_data=8'hA5.
- Streaming: FIFO holds 8'h01..8'h10, out_ready=1 throughout -> 16 consecutive cycles of out_valid=1 with data 01..10 in order. out_count stays 1 in steady state. rinc drops once rempty rises.
- Backpressure: FIFO holds 8'h11, 8'h22, 8'h33, out_ready=0 -> out_count reaches 2, rinc=0, out_data=8'h11 stable. Release out_ready -> consumer receives 11, 22, 33 in order.
- Empty boundary: single word 8'h7E written, rempty toggles 1->0->1 -> exactly one rinc pulse and one word 8'h7E delivered. No further rinc while rempty=1.
- Flush: out_count=2 holding 8'hAA and 8'hBB, FIFO holds 8'hCC, pulse rflush for one cycle -> out_count=0 and no rinc in the flush cycle. Next delivered word is 8'hCC.
- Mid-operation reset: assert rrst_n low while out_count=2 -> out_valid, out_count and out_data go to 0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/rd_fwft_buffer.sv
// Read-side first-word-fall-through output stage of the async FIFO.
// Pulls words from the FIFO memory whenever there is room and presents
// them to the consumer as a valid/ready stream. A head register drives
// out_data and a skid register catches the word that was already being
// read when the consumer stalled, so rinc never depends on out_ready.
module rd_fwft_buffer #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rempty,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 rinc,
  input  logic                 rflush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [1:0]           out_count
);

  localparam logic [1:0] CNT_ZERO = 2'd0;
  localparam logic [1:0] CNT_ONE  = 2'd1;
  localparam logic [1:0] CNT_TWO  = 2'd2;

  logic [1:0]           count_q, count_d;
  logic [DATA_SIZE-1:0] head_q,  head_d;
  logic [DATA_SIZE-1:0] skid_q,  skid_d;
  logic                 push;
  logic                 pop;

  // Read strobe and handshake decode; rinc is held low while in reset so
  // the read pointer cannot advance before the buffer is live.
  always_comb begin
    rinc      = rrst_n & ~rempty & (count_q != CNT_TWO) & ~rflush;
    push      = rinc;
    out_valid = (count_q != CNT_ZERO);
    pop       = out_valid & out_ready;
    out_data  = head_q;
    out_count = count_q;
  end

  // Next-state for occupancy and the two word registers; a flush only
  // empties the count, the register contents become don't-care.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (rflush) begin
      count_d = CNT_ZERO;
    end else begin
      unique case (count_q)
        CNT_ZERO: begin
          if (push) begin
            head_d  = rdata;
            count_d = CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (push && !pop) begin
            skid_d  = rdata;
            count_d = CNT_TWO;
          end else if (push && pop) begin
            head_d  = rdata;
            count_d = CNT_ONE;
          end else if (!push && pop) begin
            count_d = CNT_ZERO;
          end
        end
        CNT_TWO: begin
          // push cannot occur here because rinc is gated on count_q != 2
          if (pop) begin
            head_d  = skid_q;
            count_d = CNT_ONE;
          end
        end
        default: begin
          count_d = CNT_ZERO;
        end
      endcase
    end
  end

  // State registers, cleared asynchronously so a mid-transfer reset drops
  // out_valid without waiting for a clock edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      count_q <= CNT_ZERO;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_rd_fwft_buffer.sv
// Directed bench for rd_fwft_buffer with a queue standing in for the FIFO.
module tb_rd_fwft_buffer;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rempty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       rinc;
  logic       rflush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] got_q[$];

  rd_fwft_buffer #(.DATA_SIZE(8)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .rflush    (rflush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 rclk = ~rclk;

  // Continuous property checks, sampled mid-cycle.
  logic       hold_s = 1'b0;
  logic [7:0] held_s = 8'h00;
  always @(negedge rclk) begin
    if (rrst_n) begin
      if (out_count === 2'd3) begin
        fails = fails + 1;
        $display("FAIL count_range: out_count=%0d required <=2", out_count);
      end
      if (rinc && rempty) begin
        fails = fails + 1;
        $display("FAIL rinc_when_empty: rinc=%0b rempty=%0b required rinc=0", rinc, rempty);
      end
      if (rinc && out_count == 2'd2) begin
        fails = fails + 1;
        $display("FAIL rinc_when_full: rinc=%0b out_count=%0d required rinc=0", rinc, out_count);
      end
      if (hold_s && out_valid && out_data !== held_s) begin
        fails = fails + 1;
        $display("FAIL data_stable: out_data=%h required %h", out_data, held_s);
      end
    end
    hold_s <= rrst_n && out_valid && !out_ready && !rflush;
    held_s <= out_data;
  end

  task automatic refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // One clock: the FIFO model and consumer act on what was visible before the edge.
  task automatic cycle();
    logic       r;
    logic       p;
    logic [7:0] d;
    r = rinc;
    p = out_valid && out_ready;
    d = out_data;
    @(posedge rclk);
    #1;
    if (r) void'(fifo_q.pop_front());
    if (p) got_q.push_back(d);
    refresh();
    #1;
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    out_ready = 1'b0;
    fifo_q = {8'hA5};
    refresh();
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    tests++; if (out_count !== 2'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", out_count); end
    tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL rst_rinc: got %b want 0", rinc); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL rst_data: got %h want 00", out_data); end
    @(negedge rclk);
    rrst_n = 1'b1;
    #1;
    tests++; if (rinc !== 1'b1) begin fails++; $display("FAIL rel_rinc: got %b want 1", rinc); end
    cycle();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rel_valid: got %b want 1", out_valid); end
    tests++; if (out_data !== 8'hA5) begin fails++; $display("FAIL rel_data: got %h want a5", out_data); end
    tests++; if (out_count !== 2'd1) begin fails++; $display("FAIL rel_count: got %0d want 1", out_count); end
    tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL rel_rinc_empty: got %b want 0", rinc); end
    out_ready = 1'b1;
    cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rel_drain: got %b want 0", out_valid); end
    tests++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin fails++; $display("FAIL rel_recv: got %0d words want 1 word a5", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_stream();
    int bad;
    out_ready = 1'b1;
    fifo_q.delete();
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    refresh();
    #1;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      tests++; if (out_valid !== 1'b1 || out_data !== 8'(k)) begin fails++; $display("FAIL stream_word%0d: valid=%b data=%h want valid=1 data=%h", k, out_valid, out_data, 8'(k)); end
      tests++; if (out_count !== 2'd1) begin fails++; $display("FAIL stream_count%0d: got %0d want 1", k, out_count); end
      tests++; if (rinc !== (k < 16)) begin fails++; $display("FAIL stream_rinc%0d: got %b want %b", k, rinc, (k < 16)); end
    end
    cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_end: got %b want 0", out_valid); end
    bad = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(i + 1)) bad++;
    tests++; if (got_q.size() != 16 || bad != 0) begin fails++; $display("FAIL stream_order: got %0d words %0d wrong want 16 in order", got_q.size(), bad); end
    got_q.delete();
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    fifo_q = {8'h11, 8'h22, 8'h33};
    refresh();
    #1;
    cycle();
    cycle();
    tests++; if (out_count !== 2'd2) begin fails++; $display("FAIL bp_count: got %0d want 2", out_count); end
    tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL bp_rinc: got %b want 0", rinc); end
    tests++; if (out_data !== 8'h11) begin fails++; $display("FAIL bp_data: got %h want 11", out_data); end
    cycle();
    tests++; if (out_data !== 8'h11 || out_count !== 2'd2) begin fails++; $display("FAIL bp_hold: data=%h count=%0d want 11/2", out_data, out_count); end
    tests++; if (fifo_q.size() != 1) begin fails++; $display("FAIL bp_fifo: %0d left want 1", fifo_q.size()); end
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 10) begin cycle(); n++; end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_timeout: valid=%b after %0d cycles want 0", out_valid, n); end
    tests++; if (got_q.size() != 3 || got_q[0] !== 8'h11 || got_q[1] !== 8'h22 || got_q[2] !== 8'h33) begin
      fails++; $display("FAIL bp_order: got %0d words want 11 22 33", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_empty_boundary();
    int pulses;
    out_ready = 1'b1;
    fifo_q.delete();
    refresh();
    #1;
    tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL eb_idle_rinc: got %b want 0", rinc); end
    cycle();
    fifo_q = {8'h7E};
    refresh();
    #1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (rinc) pulses++;
      cycle();
      if (k == 0) begin
        tests++; if (out_valid !== 1'b1 || out_data !== 8'h7E) begin fails++; $display("FAIL eb_word: valid=%b data=%h want 1/7e", out_valid, out_data); end
      end
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL eb_pulses: got %0d want 1", pulses); end
    tests++; if (rinc !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL eb_quiet: rinc=%b valid=%b want 0/0", rinc, out_valid); end
    tests++; if (got_q.size() != 1 || got_q[0] !== 8'h7E) begin fails++; $display("FAIL eb_recv: got %0d words want 1 word 7e", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_flush();
    int n;
    out_ready = 1'b0;
    fifo_q = {8'hAA, 8'hBB, 8'hCC};
    refresh();
    #1;
    cycle();
    cycle();
    tests++; if (out_count !== 2'd2 || out_data !== 8'hAA) begin fails++; $display("FAIL fl_pre: count=%0d data=%h want 2/aa", out_count, out_data); end
    rflush = 1'b1;
    #1;
    tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL fl_rinc2: got %b want 0", rinc); end
    cycle();
    rflush = 1'b0;
    #1;
    tests++; if (out_count !== 2'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL fl_cleared: count=%0d valid=%b want 0/0", out_count, out_valid); end
    tests++; if (fifo_q.size() != 1) begin fails++; $display("FAIL fl_fifo_kept: %0d left want 1", fifo_q.size()); end
    cycle();
    tests++; if (out_valid !== 1'b1 || out_data !== 8'hCC) begin fails++; $display("FAIL fl_next: valid=%b data=%h want 1/cc", out_valid, out_data); end
    // flush at count 1 while the FIFO still has data: the read must be suppressed
    fifo_q.push_back(8'hDD);
    refresh();
    rflush = 1'b1;
    #1;
    tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL fl_rinc1: got %b want 0", rinc); end
    cycle();
    rflush = 1'b0;
    #1;
    tests++; if (out_count !== 2'd0 || fifo_q.size() != 1) begin fails++; $display("FAIL fl_c1: count=%0d fifo=%0d want 0/1", out_count, fifo_q.size()); end
    out_ready = 1'b1;
    cycle();
    n = 0;
    while (out_valid && n < 10) begin cycle(); n++; end
    tests++; if (got_q.size() != 1 || got_q[0] !== 8'hDD) begin fails++; $display("FAIL fl_recv: got %0d words want 1 word dd", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    fifo_q = {8'h41, 8'h42};
    refresh();
    #1;
    cycle();
    cycle();
    tests++; if (out_count !== 2'd2 || out_data !== 8'h41) begin fails++; $display("FAIL mr_pre: count=%0d data=%h want 2/41", out_count, out_data); end
    #1;
    rrst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_count !== 2'd0) begin fails++; $display("FAIL mr_async: valid=%b count=%0d want 0/0", out_valid, out_count); end
    tests++; if (out_data !== 8'h00 || rinc !== 1'b0) begin fails++; $display("FAIL mr_data: data=%h rinc=%b want 00/0", out_data, rinc); end
    @(negedge rclk);
    fifo_q.delete();
    refresh();
    rrst_n = 1'b1;
    #1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_midreset();
    repeat (2) @(posedge rclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
